// File: rtl/gray_sequence_checker.sv
// Checks a Gray-coded counter stream for legal single steps and tracks lock.
// Latency: 1 cycle from a sampled gray_in to bin_out, locked and err.
// Backpressure: none; samples are taken only on cycles where en=1.
//
// Ports:
//   clock      rising-edge clock
//   Reset      asynchronous active-low reset
//   en         sample enable, one Gray word per enabled cycle
//   gray_in    Gray-coded count from the counter under test
//   clr        synchronous clear of err_count (wins over an increment)
//   bin_out    binary decode of the last sampled word
//   locked     high while the FSM is in LOCKED (straight from the state register)
//   err        one-cycle pulse for each error counted while locked
//   err_count  saturating error count
//
// Optional feature: define GRAY_CHK_BIDIR_EN to accept down-count steps
// (new = prev - 1, including the wrap from 0 to all-ones) as legal.
module gray_sequence_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             en,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  // The good-step counter never needs to hold more than LOCK_CNT.
  localparam int CNT_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] good_q, good_nxt;
  logic [WIDTH-1:0] bin_q;      // doubles as the previous sample
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [WIDTH-1:0] dec;
  logic             is_hold;
  logic             is_up;
  logic             is_step;
  logic             err_hit;
  logic [CNT_W-1:0] good_inc;

  // Gray to binary: each binary bit is the XOR of the Gray bits at and above it.
  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = ^(gray_in >> i);
    end
  end

  // Classification against the previous sample; modular arithmetic makes
  // the all-ones to zero wrap an ordinary step.
  assign is_hold = (dec == bin_q);
  assign is_up   = (dec == (bin_q + WIDTH'(1)));
`ifdef GRAY_CHK_BIDIR_EN
  assign is_step = is_up || (dec == (bin_q - WIDTH'(1)));
`else
  assign is_step = is_up;
`endif

  assign good_inc = good_q + CNT_W'(1);

  always_comb begin
    state_nxt = state_q;
    good_nxt  = good_q;
    err_hit   = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          // First sample only seeds the previous-word register.
          state_nxt = ACQ;
          good_nxt  = '0;
        end
        ACQ: begin
          if (is_hold) begin
            state_nxt = ACQ;
          end else if (is_step) begin
            good_nxt = good_inc;
            if (good_inc >= LOCK_VAL) begin
              state_nxt = LOCKED;
            end
          end else begin
            // Errors while acquiring are not counted, only restart acquisition.
            good_nxt = '0;
          end
        end
        LOCKED: begin
          if (!is_hold && !is_step) begin
            err_hit   = 1'b1;
            good_nxt  = '0;
            state_nxt = ACQ;
          end
        end
        default: begin
          state_nxt = IDLE;
          good_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      good_q    <= '0;
      bin_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_nxt;
      good_q  <= good_nxt;
      err_q   <= err_hit;
      if (en) begin
        bin_q <= dec;
      end
      if (clr) begin
        err_cnt_q <= '0;
      end else if (err_hit && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
    end
  end

  assign bin_out   = bin_q;
  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_sequence_checker.sv
// Self-checking bench for gray_sequence_checker (WIDTH=4, LOCK_CNT=2, ERR_W=8).
// Inputs change on the falling edge; outputs are compared 1 time unit after
// the rising edge against expectations queued when each word is driven.
module tb_gray_sequence_checker;

  logic       clock;
  logic       Reset;
  logic       en;
  logic [3:0] gray_in;
  logic       clr;
  logic [3:0] bin_out;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] bin;
    logic       lk;
    logic       er;
    logic [7:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic [3:0] gray;
    logic       clr;
    exp_t       exp;
  } vec_t;

  exp_t sbq[$];

  gray_sequence_checker #(
    .WIDTH   (4),
    .LOCK_CNT(2),
    .ERR_W   (8)
  ) dut (
    .clock    (clock),
    .Reset    (Reset),
    .en       (en),
    .gray_in  (gray_in),
    .clr      (clr),
    .bin_out  (bin_out),
    .locked   (locked),
    .err      (err),
    .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] g2(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic exp_t mk(input int b, input logic lk, input logic er, input int c);
    exp_t x;
    x.bin = b[3:0];
    x.lk  = lk;
    x.er  = er;
    x.cnt = c[7:0];
    return x;
  endfunction

  task automatic compare(input exp_t x, input string nm);
    exp_t act;
    act = '{bin: bin_out, lk: locked, er: err, cnt: err_count};
    checks++;
    if (act !== x) begin
      failures++;
      $display("FAIL %s: got bin=%0d locked=%b err=%b cnt=%0d, want bin=%0d locked=%b err=%b cnt=%0d",
               nm, act.bin, act.lk, act.er, act.cnt, x.bin, x.lk, x.er, x.cnt);
    end
  endtask

  task automatic apply(input logic e, input logic [3:0] g, input logic c, input exp_t x,
                       input string nm);
    exp_t want;
    @(negedge clock);
    en      = e;
    gray_in = g;
    clr     = c;
    sbq.push_back(x);
    @(posedge clock);
    #1;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got nothing to compare, want one entry", nm);
    end else begin
      checks--;
      want = sbq.pop_front();
      compare(want, nm);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clock);
    en      = 1'b0;
    clr     = 1'b0;
    gray_in = 4'b0000;
    Reset   = 1'b0;
    #2;
    // Asynchronous: outputs must be cleared before any clock edge.
    compare(mk(0, 1'b0, 1'b0, 0), nm);
    @(negedge clock);
    Reset = 1'b1;
  endtask

  vec_t tbl[15];

  initial begin
    int b;
    int bad;
    int ec;

    Reset   = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    gray_in = 4'b0000;

    // Acquisition, error injection at bin 3, relock, en=0 hold, HOLD sample.
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, mk(0, 0, 0, 0)};
    tbl[1]  = '{1'b1, 4'b0001, 1'b0, mk(1, 0, 0, 0)};
    tbl[2]  = '{1'b1, 4'b0011, 1'b0, mk(2, 1, 0, 0)};
    tbl[3]  = '{1'b1, 4'b0111, 1'b0, mk(5, 0, 1, 1)};
    tbl[4]  = '{1'b1, 4'b0101, 1'b0, mk(6, 0, 0, 1)};
    tbl[5]  = '{1'b1, 4'b0100, 1'b0, mk(7, 1, 0, 1)};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, mk(7, 1, 0, 1)};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, mk(7, 1, 0, 1)};
    tbl[8]  = '{1'b0, 4'b1010, 1'b0, mk(7, 1, 0, 1)};
    tbl[9]  = '{1'b0, 4'b0011, 1'b0, mk(7, 1, 0, 1)};
    tbl[10] = '{1'b0, 4'b0110, 1'b0, mk(7, 1, 0, 1)};
    tbl[11] = '{1'b1, 4'b0100, 1'b0, mk(7, 1, 0, 1)};
    tbl[12] = '{1'b1, 4'b0100, 1'b0, mk(7, 1, 0, 1)};
    tbl[13] = '{1'b0, 4'b1001, 1'b1, mk(7, 1, 0, 0)};
    tbl[14] = '{1'b1, 4'b1100, 1'b0, mk(8, 1, 0, 0)};

    repeat (2) @(posedge clock);
    do_reset("reset_state");

    for (int i = 0; i < 3; i++) begin
      apply(tbl[i].en, tbl[i].gray, tbl[i].clr, tbl[i].exp, $sformatf("acquire_%0d", i));
    end

    // Full up-count across the 15 -> 0 wrap while locked.
    for (int i = 3; i < 20; i++) begin
      apply(1'b1, g2(i % 16), 1'b0, mk(i % 16, 1, 0, 0), $sformatf("upcount_%0d", i));
    end

    for (int i = 3; i < 15; i++) begin
      apply(tbl[i].en, tbl[i].gray, tbl[i].clr, tbl[i].exp, $sformatf("table_%0d", i));
    end

    // Mid-sequence reset discards lock; then lock and step down.
    do_reset("reset_midseq");
    apply(1'b1, 4'b0000, 1'b0, mk(0, 0, 0, 0), "dn_seed");
    apply(1'b1, 4'b0001, 1'b0, mk(1, 0, 0, 0), "dn_up1");
    apply(1'b1, 4'b0011, 1'b0, mk(2, 1, 0, 0), "dn_lock");
`ifdef GRAY_CHK_BIDIR_EN
    apply(1'b1, 4'b0001, 1'b0, mk(1, 1, 0, 0), "dn_step1");
    apply(1'b1, 4'b0000, 1'b0, mk(0, 1, 0, 0), "dn_step0");
    apply(1'b1, 4'b1000, 1'b0, mk(15, 1, 0, 0), "dn_wrap");
`else
    apply(1'b1, 4'b0001, 1'b0, mk(1, 0, 1, 1), "dn_step1");
    apply(1'b1, 4'b0000, 1'b0, mk(0, 0, 0, 1), "dn_step0");
    apply(1'b1, 4'b1000, 1'b0, mk(15, 0, 0, 1), "dn_wrap");
`endif

    // 300 locked errors: jump +2 (error), then two legal steps to relock.
    do_reset("reset_sat");
    apply(1'b1, 4'b0000, 1'b0, mk(0, 0, 0, 0), "sat_seed");
    apply(1'b1, 4'b0001, 1'b0, mk(1, 0, 0, 0), "sat_up1");
    apply(1'b1, 4'b0011, 1'b0, mk(2, 1, 0, 0), "sat_lock");
    b  = 2;
    ec = 0;
    for (int k = 1; k <= 300; k++) begin
      bad = (b + 2) % 16;
      if (ec < 255) ec++;
      apply(1'b1, g2(bad), 1'b0, mk(bad, 0, 1, ec), $sformatf("sat_err_%0d", k));
      apply(1'b1, g2(bad + 1), 1'b0, mk((bad + 1) % 16, 0, 0, ec), $sformatf("sat_re1_%0d", k));
      apply(1'b1, g2(bad + 2), 1'b0, mk((bad + 2) % 16, 1, 0, ec), $sformatf("sat_re2_%0d", k));
      b = (bad + 2) % 16;
    end
    compare(mk(b, 1, 0, 255), "sat_final");

    // clr together with an error: count clears, err still pulses.
    bad = (b + 2) % 16;
    apply(1'b1, g2(bad), 1'b1, mk(bad, 0, 1, 0), "clr_with_err");
    apply(1'b1, g2(bad + 1), 1'b0, mk((bad + 1) % 16, 0, 0, 0), "clr_after");

    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d leftover entries, want 0", sbq.size());
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
